// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns raw PS/2 set-2 bytes from the keyboard receiver FIFO into key
//   events. E0/F0 prefixes are folded into the event, shift and caps-lock
//   are tracked, printable keys get an ASCII value, typematic repeats of
//   the held key are flagged and new presses are counted.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   kbd_data        byte at the receiver FIFO head (valid while kbd_ready)
//   kbd_ready       receiver FIFO non-empty
//   kbd_nextdata_n  active-low pop strobe, low in the cycle a byte is taken
//   ev_valid/ready  event handshake toward the consumer
//   ev_code         scancode without prefixes
//   ev_ext/ev_break E0 / F0 prefix seen
//   ev_repeat       typematic repeat of the currently held key
//   ev_ascii        ASCII translation, 0x00 if not printable
//   shift, caps     modifier state
//   press_cnt       count of new (non-repeat) make events, wraps
module ps2_scancode_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kbd_data,
  input  logic             kbd_ready,
  output logic             kbd_nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_repeat,
  output logic [7:0]       ev_ascii,
  output logic             shift,
  output logic             caps,
  output logic [CNT_W-1:0] press_cnt
);

  typedef enum logic [1:0] {IDLE, PROC, OUT} state_t;

  state_t     state;
  logic [7:0] byte_r;
  logic       ext_f;
  logic       brk_f;
  logic       lshift;
  logic       rshift;
  logic       held;
  logic [8:0] held_key;   // {ext, code} of the last new make

  logic       held_match;
  logic       is_repeat;
  logic       is_discard;
  logic [7:0] ascii_next;

  // Translation of a non-extended make code; sh/cp are the modifier
  // states before this event is applied.
  function automatic logic [7:0] to_ascii(input logic [7:0] code,
                                          input logic sh, input logic cp);
    logic [7:0] letter;
    logic [7:0] res;
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned (that would infer a latch).
    letter = 8'h00;
    res    = 8'h00;
    case (code)
      8'h1C: letter = "A";  8'h32: letter = "B";  8'h21: letter = "C";
      8'h23: letter = "D";  8'h24: letter = "E";  8'h2B: letter = "F";
      8'h34: letter = "G";  8'h33: letter = "H";  8'h43: letter = "I";
      8'h3B: letter = "J";  8'h42: letter = "K";  8'h4B: letter = "L";
      8'h3A: letter = "M";  8'h31: letter = "N";  8'h44: letter = "O";
      8'h4D: letter = "P";  8'h15: letter = "Q";  8'h2D: letter = "R";
      8'h1B: letter = "S";  8'h2C: letter = "T";  8'h3C: letter = "U";
      8'h2A: letter = "V";  8'h1D: letter = "W";  8'h22: letter = "X";
      8'h35: letter = "Y";  8'h1A: letter = "Z";
      8'h16: res = sh ? 8'h21 : 8'h31;  // ! 1
      8'h1E: res = sh ? 8'h40 : 8'h32;  // @ 2
      8'h26: res = sh ? 8'h23 : 8'h33;  // # 3
      8'h25: res = sh ? 8'h24 : 8'h34;  // $ 4
      8'h2E: res = sh ? 8'h25 : 8'h35;  // % 5
      8'h36: res = sh ? 8'h5E : 8'h36;  // ^ 6
      8'h3D: res = sh ? 8'h26 : 8'h37;  // & 7
      8'h3E: res = sh ? 8'h2A : 8'h38;  // * 8
      8'h46: res = sh ? 8'h28 : 8'h39;  // ( 9
      8'h45: res = sh ? 8'h29 : 8'h30;  // ) 0
      8'h29: res = 8'h20;               // space
      8'h5A: res = 8'h0D;               // enter
      8'h66: res = 8'h08;               // backspace
      8'h76: res = 8'h1B;               // escape
      default: res = 8'h00;
    endcase
    // Lower case is the upper-case letter with bit 5 set.
    if (letter != 8'h00) res = (sh ^ cp) ? letter : (letter | 8'h20);
    return res;
  endfunction

  // Pop is combinational so the receiver advances on the same edge that
  // latches the byte; reset suppresses it.
  assign kbd_nextdata_n = ~((state == IDLE) & kbd_ready & ~rst);
  assign shift          = lshift | rshift;

  assign held_match = held && ({ext_f, byte_r} == held_key);
  assign is_repeat  = ~brk_f & held_match;
  assign ascii_next = (ext_f | brk_f) ? 8'h00 : to_ascii(byte_r, shift, caps);

  always_comb begin
    case (byte_r)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFF: is_discard = 1'b1;
      default:                                  is_discard = 1'b0;
    endcase
  end

  // NOTE: all state here is sequential and uses non-blocking assignments,
  // so every read in this block sees the value from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_r    <= 8'h00;
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps      <= 1'b0;
      held      <= 1'b0;
      held_key  <= 9'h000;
      press_cnt <= '0;
      ev_valid  <= 1'b0;
      ev_code   <= 8'h00;
      ev_ext    <= 1'b0;
      ev_break  <= 1'b0;
      ev_repeat <= 1'b0;
      ev_ascii  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (kbd_ready) begin
            byte_r <= kbd_data;
            state  <= PROC;
          end
        end

        PROC: begin
          state <= IDLE;
          if (byte_r == 8'hE0) begin
            ext_f <= 1'b1;
          end else if (byte_r == 8'hF0) begin
            brk_f <= 1'b1;
          end else if (is_discard) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end else begin
            ev_valid  <= 1'b1;
            ev_code   <= byte_r;
            ev_ext    <= ext_f;
            ev_break  <= brk_f;
            ev_repeat <= is_repeat;
            ev_ascii  <= ascii_next;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
            state     <= OUT;

            if (!brk_f && !is_repeat) begin
              held      <= 1'b1;
              held_key  <= {ext_f, byte_r};
              press_cnt <= press_cnt + CNT_W'(1);
            end else if (brk_f && held_match) begin
              held <= 1'b0;
            end

            if (!ext_f) begin
              if (byte_r == 8'h12) lshift <= ~brk_f;
              if (byte_r == 8'h59) rshift <= ~brk_f;
              if (byte_r == 8'h58 && !brk_f && !is_repeat) caps <= ~caps;
            end
          end
        end

        OUT: begin
          // Fields hold until accepted; no pop here, so backpressure
          // stalls into the receiver FIFO.
          if (ev_ready) begin
            ev_valid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: a receiver-FIFO model feeds bytes,
// a table-driven reference model predicts each event into a queue, and a
// monitor pops and compares every accepted event.
module tb_ps2_scancode_decoder;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       kbd_data = 8'h00;
  logic             kbd_ready = 1'b0;
  logic             kbd_nextdata_n;
  logic             ev_valid;
  logic             ev_ready = 1'b0;
  logic [7:0]       ev_code;
  logic             ev_ext;
  logic             ev_break;
  logic             ev_repeat;
  logic [7:0]       ev_ascii;
  logic             shift;
  logic             caps;
  logic [CNT_W-1:0] press_cnt;

  ps2_scancode_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .kbd_data(kbd_data), .kbd_ready(kbd_ready), .kbd_nextdata_n(kbd_nextdata_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break),
    .ev_repeat(ev_repeat), .ev_ascii(ev_ascii),
    .shift(shift), .caps(caps), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       code;
    logic             ext;
    logic             brk;
    logic             rep;
    logic [7:0]       ascii;
    logic             shift;
    logic             caps;
    logic [CNT_W-1:0] cnt;
  } ev_t;

  int errors = 0;
  int checks = 0;

  ev_t        exp_q[$];
  logic [7:0] rx_q[$];
  bit         mon_en   = 1'b0;
  bit         rand_rdy = 1'b0;

  // ---------------- reference model (key-table lookup) ----------------
  byte unsigned letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  // index i is the code of digit i
  byte unsigned digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};
  string shifted_digits = ")!@#$%^&*(";

  bit         m_ext, m_brk, m_held, m_ls, m_rs, m_caps;
  logic [8:0] m_key;
  int         m_cnt;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_ls = 0; m_rs = 0; m_caps = 0;
    m_key = '0; m_cnt = 0;
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] b, input bit sh,
                                           input bit cp);
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == b) return (sh ^ cp) ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == b) return sh ? 8'(shifted_digits[i]) : 8'(48 + i);
    if (b == 8'h29) return 8'h20;
    if (b == 8'h5A) return 8'h0D;
    if (b == 8'h66) return 8'h08;
    if (b == 8'h76) return 8'h1B;
    return 8'h00;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    bit  rep;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      rep     = !m_brk && m_held && (m_key == {m_ext, b});
      e.code  = b;
      e.ext   = m_ext;
      e.brk   = m_brk;
      e.rep   = rep;
      e.ascii = (m_ext || m_brk) ? 8'h00 : ref_ascii(b, m_ls | m_rs, m_caps);
      if (!m_brk && !rep) begin
        m_held = 1; m_key = {m_ext, b}; m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end else if (m_brk && m_held && m_key == {m_ext, b}) m_held = 0;
      if (!m_ext) begin
        if (b == 8'h12) m_ls = !m_brk;
        if (b == 8'h59) m_rs = !m_brk;
        if (b == 8'h58 && !m_brk && !rep) m_caps = !m_caps;
      end
      e.shift = m_ls | m_rs;
      e.caps  = m_caps;
      e.cnt   = CNT_W'(m_cnt);
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic push(input logic [7:0] b);
    rx_q.push_back(b);
    model_byte(b);
    kbd_ready = 1'b1;
    kbd_data  = rx_q[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || ev_valid) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) timeout(name);
    repeat (3) tick();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!ev_valid && n < 50) begin
      tick();
      n++;
    end
    if (!ev_valid) timeout(name);
  endtask

  // Receiver FIFO: pop decided from the strobe sampled mid-cycle, applied
  // just after the edge that the DUT latched the byte on.
  initial begin
    bit pop;
    forever begin
      @(negedge clk);
      pop = !kbd_nextdata_n;
      @(posedge clk);
      #1;
      if (pop && rx_q.size() != 0) void'(rx_q.pop_front());
      kbd_ready = (rx_q.size() != 0);
      kbd_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    end
  end

  // Random consumer readiness.
  initial begin
    forever begin
      tick();
      if (rand_rdy) ev_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    ev_t got;
    ev_t exp;
    if (mon_en && !rst && ev_valid && ev_ready) begin
      got = '{ev_code, ev_ext, ev_break, ev_repeat, ev_ascii, shift, caps, press_cnt};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got 0x%0h with no event expected", got);
      end else begin
        exp = exp_q.pop_front();
        check("event{code,ext,brk,rep,ascii,shift,caps,cnt}", 32'(got), 32'(exp));
      end
    end
  end

  function automatic logic [7:0] rand_byte();
    byte unsigned pool[24] = '{8'h1C, 8'h32, 8'h1A, 8'h4D, 8'h16, 8'h45, 8'h3E,
      8'h12, 8'h59, 8'h58, 8'hE0, 8'hF0, 8'hF0, 8'h29, 8'h5A, 8'h66, 8'h76,
      8'h75, 8'h00, 8'hAA, 8'hFA, 8'h1C, 8'h1C, 8'h58};
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    return pool[$urandom_range(0, 23)];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] snap;
    int          cnt0;

    model_reset();
    repeat (3) tick();
    @(negedge clk);
    check("reset_ev_valid", 32'(ev_valid), 0);
    check("reset_code_ascii", {16'h0, ev_code, ev_ascii}, 0);
    check("reset_flags", {ev_ext, ev_break, ev_repeat, shift, caps}, 0);
    check("reset_press_cnt", 32'(press_cnt), 0);
    check("reset_pop_n", 32'(kbd_nextdata_n), 1);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    ev_ready = 1'b1;
    tick();

    // Latency: byte at the head in IDLE at cycle t, ev_valid at t+2.
    push(8'h1C);
    @(negedge clk);
    check("pop_strobe_low", 32'(kbd_nextdata_n), 0);
    tick();
    check("latency_t1_not_valid", 32'(ev_valid), 0);
    tick();
    check("latency_t2_valid", 32'(ev_valid), 1);
    push(8'hF0); push(8'h1C);
    drain("t1_drain");
    check("t1_press_cnt", 32'(press_cnt), 1);

    // Shift.
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h12); push(8'h1C);
    drain("shift_drain");
    check("shift_released", 32'(shift), 0);

    // Caps lock and repeat suppression of the toggle.
    push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
    push(8'h58); push(8'h58); push(8'h58);
    drain("caps_drain");
    check("caps_single_toggle", 32'(caps), 0);

    // Extended keys and typematic repeat.
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain("ext_drain");
    cnt0 = int'(press_cnt);
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain("repeat_drain");
    check("repeat_cnt_plus_one", 32'(press_cnt), 32'((cnt0 + 1) % 256));

    // Backpressure: 4 bytes queued, consumer stalled for 20 cycles.
    ev_ready = 1'b0;
    push(8'h32); push(8'h21); push(8'h23); push(8'h24);
    wait_valid("bp_wait_valid");
    @(negedge clk);
    snap = {7'h0, ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ev_ascii, shift, caps, press_cnt};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_pop_n_high", 32'(kbd_nextdata_n), 1);
      check("bp_fields_stable",
            {7'h0, ev_valid, ev_code, ev_ext, ev_break, ev_repeat, ev_ascii, shift, caps, press_cnt},
            snap);
    end
    check("bp_fifo_left", rx_q.size(), 3);
    tick();
    ev_ready = 1'b1;
    drain("bp_drain");

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (rx_q.size() < 4 && $urandom_range(0, 2) != 0) push(rand_byte());
      tick();
    end
    rand_rdy = 1'b0;
    ev_ready = 1'b1;
    drain("rand_drain");

    // Reset while holding an event in OUT.
    ev_ready = 1'b0;
    push(8'h58);
    wait_valid("rst_wait_valid");
    check("rst_pre_caps", 32'(caps), 32'(m_caps));
    push(8'h1C);
    rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    check("rst_cycle_no_pop", 32'(kbd_nextdata_n), 1);
    tick();
    rx_q.delete();
    exp_q.delete();
    kbd_ready = 1'b0;
    kbd_data = 8'h00;
    model_reset();
    @(negedge clk);
    check("rst_ev_valid", 32'(ev_valid), 0);
    check("rst_caps", 32'(caps), 0);
    check("rst_press_cnt", 32'(press_cnt), 0);
    check("rst_pop_n", 32'(kbd_nextdata_n), 1);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    ev_ready = 1'b1;
    tick();
    push(8'h1C);
    drain("post_rst_drain");
    check("post_rst_press_cnt", 32'(press_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
